bcd_to_c2_encoder: RTL



---
 rtl/bcd_to_c2_encoder.sv | 113 +++++++++++
 1 files changed

// File: rtl/bcd_to_c2_encoder.sv
// Signed three-digit BCD (sign + hundreds/tens/units) to DW_OUT-bit two's complement.
// Three accumulate cycles (acc*10 + digit via shift-add), then a single range-check cycle.
module bcd_to_c2_encoder #(
    parameter int DW_OUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sign,
    input  logic [3:0]        bcd_hundreds,
    input  logic [3:0]        bcd_tens,
    input  logic [3:0]        bcd_units,
    output logic [DW_OUT-1:0] number,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, ACC, CHECK} state_t;

    // Range limits widened to 11 bits so DW_OUT=11 limits stay representable.
    localparam logic [10:0] MAX_NEG = 11'(1 << (DW_OUT - 1));
    localparam logic [10:0] MAX_POS = MAX_NEG - 11'd1;

    state_t              state_q;
    logic                sign_q;
    logic [3:0]          hund_q, tens_q, units_q;
    logic [9:0]          acc_q;
    logic [1:0]          idx_q;
    logic                bad_q;
    logic [DW_OUT-1:0]   number_q;
    logic                busy_q, done_q, error_q;

    logic [3:0]          digit_cur;
    logic [9:0]          acc_d;
    logic [10:0]         acc_ext;
    logic [DW_OUT-1:0]   mag_w, neg_w;
    logic                error_d;

    always_comb begin
        digit_cur = units_q;
        case (idx_q)
            2'd0:    digit_cur = hund_q;
            2'd1:    digit_cur = tens_q;
            default: digit_cur = units_q;
        endcase
    end

    assign acc_d   = {acc_q[6:0], 3'b000} + {acc_q[8:0], 1'b0} + {6'd0, digit_cur};
    assign acc_ext = {1'b0, acc_q};
    assign mag_w   = acc_ext[DW_OUT-1:0];
    assign neg_w   = ~mag_w + {{(DW_OUT-1){1'b0}}, 1'b1};
    assign error_d = bad_q | (!sign_q && (acc_ext > MAX_POS)) | (sign_q && (acc_ext > MAX_NEG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            hund_q   <= 4'd0;
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            acc_q    <= 10'd0;
            idx_q    <= 2'd0;
            bad_q    <= 1'b0;
            number_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= sign;
                        hund_q  <= bcd_hundreds;
                        tens_q  <= bcd_tens;
                        units_q <= bcd_units;
                        acc_q   <= 10'd0;
                        idx_q   <= 2'd0;
                        bad_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    bad_q <= bad_q | (digit_cur > 4'd9);
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd2) state_q <= CHECK;
                end
                CHECK: begin
                    if (error_d) begin
                        number_q <= '0;
                        error_q  <= 1'b1;
                    end else begin
                        number_q <= sign_q ? neg_w : mag_w;
                        error_q  <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign number = number_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule
